// File: rtl/spi_host_master_if.sv
// Command/response port of the SPI host master.
// The controller drives commands through the master modport; the SPI host
// master consumes them through the slave modport and returns read bytes.
interface spi_host_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_data,
    input  cmd_ready,
    input  rsp_valid,
    input  rsp_data
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_data,
    output cmd_ready,
    output rsp_valid,
    output rsp_data
  );
endinterface

// File: rtl/spi_host_master.sv
// SPI host master: serialises 10-bit RAM commands (2-bit op + 8-bit payload)
// into one SS_n-framed transfer at one bit per clk, and for read-data
// commands (op 11) captures an 8-bit MISO reply after TURNAROUND idle cycles.
// Every output is registered: the next-state logic computes the value each
// output must have in the upcoming cycle and the register stage applies it.
module spi_host_master #(
  parameter int unsigned TURNAROUND = 32'd2
) (
  input  logic                     clk,
  input  logic                     rst,
  spi_host_master_if.slave         cmd_if,
  output logic                     busy,
  output logic                     SS_n,
  output logic                     MOSI,
  input  logic                     MISO
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_SHIFT    = 3'd2,
    ST_WAIT     = 3'd3,
    ST_READ     = 3'd4,
    ST_GAP      = 3'd5
  } state_t;

  // WAIT lasts TURNAROUND cycles, counting down to zero.
  localparam logic [3:0] WAIT_LOAD = 4'(TURNAROUND - 32'd1);

  state_t     state_r, state_s;
  logic [9:0] shift_r, shift_s;
  logic [3:0] cnt_r, cnt_s;
  logic [7:0] rx_r, rx_s;
  logic       read_r, read_s;
  logic       ss_n_r, ss_n_s;
  logic       mosi_r, mosi_s;
  logic       cmd_ready_r, cmd_ready_s;
  logic       rsp_valid_r, rsp_valid_s;
  logic [7:0] rsp_data_r, rsp_data_s;
  logic       busy_r, busy_s;

  // Next-state and next-output logic; outputs describe the upcoming cycle.
  always_comb begin
    state_s     = state_r;
    shift_s     = shift_r;
    cnt_s       = cnt_r;
    rx_s        = rx_r;
    read_s      = read_r;
    ss_n_s      = 1'b1;
    mosi_s      = 1'b0;
    cmd_ready_s = 1'b0;
    rsp_valid_s = 1'b0;
    rsp_data_s  = rsp_data_r;

    case (state_r)
      ST_IDLE: begin
        if (cmd_if.cmd_valid && cmd_ready_r) begin
          state_s = ST_PREAMBLE;
          shift_s = {cmd_if.cmd_op, cmd_if.cmd_data};
          read_s  = (cmd_if.cmd_op == 2'b11);
          ss_n_s  = 1'b0;
          mosi_s  = cmd_if.cmd_op[1];
        end else begin
          cmd_ready_s = 1'b1;
        end
      end
      ST_PREAMBLE: begin
        // First SHIFT cycle presents word bit 9.
        state_s = ST_SHIFT;
        cnt_s   = 4'd9;
        ss_n_s  = 1'b0;
        mosi_s  = shift_r[9];
        shift_s = {shift_r[8:0], 1'b0};
      end
      ST_SHIFT: begin
        if (cnt_r != 4'd0) begin
          cnt_s   = cnt_r - 4'd1;
          ss_n_s  = 1'b0;
          mosi_s  = shift_r[9];
          shift_s = {shift_r[8:0], 1'b0};
        end else if (read_r) begin
          state_s = ST_WAIT;
          cnt_s   = WAIT_LOAD;
          ss_n_s  = 1'b0;
        end else begin
          state_s = ST_GAP;
        end
      end
      ST_WAIT: begin
        ss_n_s = 1'b0;
        if (cnt_r != 4'd0) begin
          cnt_s = cnt_r - 4'd1;
        end else begin
          state_s = ST_READ;
          cnt_s   = 4'd7;
          rx_s    = 8'h00;
        end
      end
      ST_READ: begin
        // MISO is sampled at the edge that ends each READ cycle.
        rx_s = {rx_r[6:0], MISO};
        if (cnt_r != 4'd0) begin
          cnt_s  = cnt_r - 4'd1;
          ss_n_s = 1'b0;
        end else begin
          state_s     = ST_GAP;
          rsp_valid_s = 1'b1;
          rsp_data_s  = {rx_r[6:0], MISO};
        end
      end
      ST_GAP: begin
        state_s     = ST_IDLE;
        cmd_ready_s = 1'b1;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    busy_s = (state_s != ST_IDLE);
  end

  // State, datapath and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      shift_r     <= 10'h000;
      cnt_r       <= 4'd0;
      rx_r        <= 8'h00;
      read_r      <= 1'b0;
      ss_n_r      <= 1'b1;
      mosi_r      <= 1'b0;
      cmd_ready_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= 8'h00;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      shift_r     <= shift_s;
      cnt_r       <= cnt_s;
      rx_r        <= rx_s;
      read_r      <= read_s;
      ss_n_r      <= ss_n_s;
      mosi_r      <= mosi_s;
      cmd_ready_r <= cmd_ready_s;
      rsp_valid_r <= rsp_valid_s;
      rsp_data_r  <= rsp_data_s;
      busy_r      <= busy_s;
    end
  end

  assign cmd_if.cmd_ready = cmd_ready_r;
  assign cmd_if.rsp_valid = rsp_valid_r;
  assign cmd_if.rsp_data  = rsp_data_r;
  assign busy             = busy_r;
  assign SS_n             = ss_n_r;
  assign MOSI             = mosi_r;

endmodule

// File: tb/tb_spi_host_master.sv
// Directed testbench for spi_host_master: frame timing, back-to-back frames,
// read capture (TA=2 and TA=5), reset mid-frame and a loop through a small
// behavioural SPI slave + RAM model.
module tb_spi_host_master;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  // 10 ns clock.
  always #5 clk = ~clk;

  spi_host_master_if if1();
  spi_host_master_if if2();

  logic busy1, ss1, mosi1, miso1;
  logic busy2, ss2, mosi2, miso2;
  logic miso_drv, slave_en, slave_miso;

  assign miso1 = slave_en ? slave_miso : miso_drv;

  spi_host_master #(.TURNAROUND(2)) dut (
    .clk(clk), .rst(rst), .cmd_if(if1), .busy(busy1),
    .SS_n(ss1), .MOSI(mosi1), .MISO(miso1)
  );

  spi_host_master #(.TURNAROUND(5)) dut_ta5 (
    .clk(clk), .rst(rst), .cmd_if(if2), .busy(busy2),
    .SS_n(ss2), .MOSI(mosi2), .MISO(miso2)
  );

  // Behavioural SPI slave + RAM (TA=2): index 0 preamble, 1..10 command
  // bits, 11..12 turnaround, 13..20 read byte on MISO.
  logic [4:0] sidx = 5'd0;
  logic [9:0] sword;
  logic [7:0] saddr, sout;
  logic [7:0] mem [256];

  // Slave frame decoder and MISO driver.
  always @(posedge clk) begin
    if (ss1 !== 1'b0) begin
      sidx       <= 5'd0;
      slave_miso <= 1'b0;
    end else begin
      sidx <= sidx + 5'd1;
      if (sidx >= 5'd1 && sidx <= 5'd10) sword <= {sword[8:0], mosi1};
      if (sidx == 5'd10) begin
        case (sword[8:7])
          2'b00:   saddr <= {sword[6:0], mosi1};
          2'b01:   mem[saddr] <= {sword[6:0], mosi1};
          2'b10:   saddr <= {sword[6:0], mosi1};
          default: sout <= mem[saddr];
        endcase
      end
      if (sidx >= 5'd12 && sidx <= 5'd19) slave_miso <= sout[3'(5'd19 - sidx)];
      else slave_miso <= 1'b0;
    end
  end

  task automatic test_reset;
    rst = 1'b1;
    if1.cmd_valid = 1'b0; if1.cmd_op = 2'b00; if1.cmd_data = 8'h00;
    if2.cmd_valid = 1'b0; if2.cmd_op = 2'b00; if2.cmd_data = 8'h00;
    miso_drv = 1'b0; miso2 = 1'b0; slave_en = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (ss1 !== 1'b1) begin errors++; $display("FAIL rst_ss_n: got %b expected 1", ss1); end
    checks++; if (mosi1 !== 1'b0) begin errors++; $display("FAIL rst_mosi: got %b expected 0", mosi1); end
    checks++; if (if1.cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready: got %b expected 0", if1.cmd_ready); end
    checks++; if (if1.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b expected 0", if1.rsp_valid); end
    checks++; if (if1.rsp_data !== 8'h00) begin errors++; $display("FAIL rst_rsp_data: got %h expected 00", if1.rsp_data); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy1); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (if1.cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b expected 1", if1.cmd_ready); end
    checks++; if (if2.cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready_ta5: got %b expected 1", if2.cmd_ready); end
  endtask

  task automatic test_write_addr;
    logic [13:1] em, es, er, eb;
    em = 13'b0010100101000;
    es = 13'b1100000000000;
    er = 13'b1000000000000;
    eb = 13'b0111111111111;
    if1.cmd_valid = 1'b1; if1.cmd_op = 2'b00; if1.cmd_data = 8'hA5;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (k == 1) begin if1.cmd_valid = 1'b0; if1.cmd_op = 2'b11; if1.cmd_data = 8'h5A; end
      checks++; if (mosi1 !== em[k]) begin errors++; $display("FAIL wa_mosi k=%0d: got %b expected %b", k, mosi1, em[k]); end
      checks++; if (ss1 !== es[k]) begin errors++; $display("FAIL wa_ss_n k=%0d: got %b expected %b", k, ss1, es[k]); end
      checks++; if (if1.cmd_ready !== er[k]) begin errors++; $display("FAIL wa_cmd_ready k=%0d: got %b expected %b", k, if1.cmd_ready, er[k]); end
      checks++; if (busy1 !== eb[k]) begin errors++; $display("FAIL wa_busy k=%0d: got %b expected %b", k, busy1, eb[k]); end
    end
  endtask

  task automatic test_back_to_back;
    logic [27:1] em, es, er;
    em = 27'b000001111000110000111100100;
    es = 27'b111000000000001100000000000;
    er = 27'b110000000000001000000000000;
    if1.cmd_valid = 1'b1; if1.cmd_op = 2'b01; if1.cmd_data = 8'h3C;
    for (int k = 1; k <= 27; k++) begin
      @(negedge clk);
      if (k == 1 || k == 14) if1.cmd_valid = 1'b0;
      checks++; if (mosi1 !== em[k]) begin errors++; $display("FAIL b2b_mosi k=%0d: got %b expected %b", k, mosi1, em[k]); end
      checks++; if (ss1 !== es[k]) begin errors++; $display("FAIL b2b_ss_n k=%0d: got %b expected %b", k, ss1, es[k]); end
      checks++; if (if1.cmd_ready !== er[k]) begin errors++; $display("FAIL b2b_cmd_ready k=%0d: got %b expected %b", k, if1.cmd_ready, er[k]); end
      if (k == 13) begin if1.cmd_valid = 1'b1; if1.cmd_op = 2'b10; if1.cmd_data = 8'h3C; end
    end
  endtask

  task automatic test_read_data;
    logic [7:0] rb;
    rb = 8'hC3;
    if1.cmd_valid = 1'b1; if1.cmd_op = 2'b11; if1.cmd_data = 8'h00;
    for (int k = 1; k <= 23; k++) begin
      @(negedge clk);
      if (k == 1) if1.cmd_valid = 1'b0;
      if (k == 1) begin checks++; if (mosi1 !== 1'b1) begin errors++; $display("FAIL rd_preamble: got %b expected 1", mosi1); end end
      checks++; if (if1.rsp_valid !== (k == 22)) begin errors++; $display("FAIL rd_rsp_valid k=%0d: got %b expected %b", k, if1.rsp_valid, (k == 22)); end
      checks++; if (ss1 !== (k >= 22)) begin errors++; $display("FAIL rd_ss_n k=%0d: got %b expected %b", k, ss1, (k >= 22)); end
      if (k == 22) begin checks++; if (if1.rsp_data !== 8'hC3) begin errors++; $display("FAIL rd_rsp_data: got %h expected c3", if1.rsp_data); end end
      if (k == 23) begin checks++; if (if1.cmd_ready !== 1'b1) begin errors++; $display("FAIL rd_cmd_ready: got %b expected 1", if1.cmd_ready); end end
      if (k >= 14 && k <= 21) miso_drv = rb[21 - k];
      else miso_drv = 1'b0;
    end
    // A following write-address frame must leave the read byte untouched.
    if1.cmd_valid = 1'b1; if1.cmd_op = 2'b00; if1.cmd_data = 8'h5F;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (k == 1) if1.cmd_valid = 1'b0;
      checks++; if (if1.rsp_data !== 8'hC3 || if1.rsp_valid !== 1'b0) begin
        errors++; $display("FAIL rd_hold k=%0d: got data=%h valid=%b expected data=c3 valid=0", k, if1.rsp_data, if1.rsp_valid);
      end
    end
  endtask

  task automatic test_reset_mid_shift;
    if1.cmd_valid = 1'b1; if1.cmd_op = 2'b00; if1.cmd_data = 8'hFF;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1) if1.cmd_valid = 1'b0;
      if (k == 5) begin rst = 1'b1; if1.cmd_valid = 1'b1; if1.cmd_op = 2'b11; end
      if (k >= 6 && k <= 8) begin
        checks++; if (ss1 !== 1'b1 || mosi1 !== 1'b0 || busy1 !== 1'b0) begin
          errors++; $display("FAIL mid_rst_frame k=%0d: got ss_n=%b mosi=%b busy=%b expected 1 0 0", k, ss1, mosi1, busy1);
        end
        checks++; if (if1.rsp_valid !== 1'b0 || if1.rsp_data !== 8'h00 || if1.cmd_ready !== 1'b0) begin
          errors++; $display("FAIL mid_rst_rsp k=%0d: got valid=%b data=%h ready=%b expected 0 00 0", k, if1.rsp_valid, if1.rsp_data, if1.cmd_ready);
        end
      end
      if (k == 8) begin rst = 1'b0; if1.cmd_valid = 1'b0; end
      if (k == 9) begin
        checks++; if (if1.cmd_ready !== 1'b1 || busy1 !== 1'b0) begin
          errors++; $display("FAIL mid_rst_release: got ready=%b busy=%b expected 1 0", if1.cmd_ready, busy1);
        end
      end
    end
  endtask

  task automatic test_ta5;
    logic [7:0] rb;
    rb = 8'h81;
    if2.cmd_valid = 1'b1; if2.cmd_op = 2'b11; if2.cmd_data = 8'h00;
    for (int k = 1; k <= 26; k++) begin
      @(negedge clk);
      if (k == 1) if2.cmd_valid = 1'b0;
      checks++; if (if2.rsp_valid !== (k == 25)) begin errors++; $display("FAIL ta5_rsp_valid k=%0d: got %b expected %b", k, if2.rsp_valid, (k == 25)); end
      checks++; if (ss2 !== (k >= 25)) begin errors++; $display("FAIL ta5_ss_n k=%0d: got %b expected %b", k, ss2, (k >= 25)); end
      if (k == 25) begin checks++; if (if2.rsp_data !== 8'h81) begin errors++; $display("FAIL ta5_rsp_data: got %h expected 81", if2.rsp_data); end end
      if (k == 26) begin checks++; if (if2.cmd_ready !== 1'b1) begin errors++; $display("FAIL ta5_cmd_ready: got %b expected 1", if2.cmd_ready); end end
      if (k >= 17 && k <= 24) miso2 = rb[24 - k];
      else miso2 = 1'b0;
    end
  endtask

  task automatic test_full_loop;
    logic [1:0] ops [4];
    logic [7:0] dat [4];
    int w;
    ops[0] = 2'b00; dat[0] = 8'h10;
    ops[1] = 2'b01; dat[1] = 8'h5A;
    ops[2] = 2'b10; dat[2] = 8'h10;
    ops[3] = 2'b11; dat[3] = 8'h00;
    slave_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w = 0;
      while (if1.cmd_ready !== 1'b1 && w < 40) begin @(negedge clk); w++; end
      checks++; if (w >= 40) begin errors++; $display("FAIL loop_ready_timeout frame=%0d: got no cmd_ready expected within 40 cycles", i); end
      if1.cmd_valid = 1'b1; if1.cmd_op = ops[i]; if1.cmd_data = dat[i];
      @(negedge clk);
      if1.cmd_valid = 1'b0;
    end
    w = 0;
    while (if1.rsp_valid !== 1'b1 && w < 40) begin @(negedge clk); w++; end
    checks++; if (w >= 40 || if1.rsp_data !== 8'h5A) begin
      errors++; $display("FAIL loop_rsp: got valid=%b data=%h expected valid=1 data=5a", if1.rsp_valid, if1.rsp_data);
    end
    slave_en = 1'b0;
  endtask

  // Hard stop in case anything stalls beyond every bounded wait.
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

  // Test sequence.
  initial begin
    test_reset();
    test_write_addr();
    test_back_to_back();
    test_read_data();
    test_reset_mid_shift();
    test_ta5();
    test_full_loop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
